// File: rtl/rx_packet_builder.sv
`default_nettype none
// ============================================================================
// Module   : rx_packet_builder
// Purpose  : Round-robin receive packetizer. Scans the data-channel FIFOs and
//            the command-reply FIFO and writes fixed 256-word packets
//            (2-word header, 2-word timestamp, 252-word payload) into the
//            USB FIFO. All logic runs in the rxclk domain.
// Revision : 1.0 - initial release
// ============================================================================
module rx_packet_builder #(
    parameter int NUM_CHAN = 1
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic [31:0]       adctime,
    input  logic [3:0]        channels,
    input  logic [15:0]       chan_fifodata,
    input  logic [NUM_CHAN:0] chan_empty,
    input  logic [9:0]        chan_usedw,
    input  logic              have_space,
    input  logic [31:0]       rssi_0,
    input  logic [31:0]       rssi_1,
    input  logic [31:0]       rssi_2,
    input  logic [31:0]       rssi_3,
    input  logic [1:0]        underrun,
    output logic [3:0]        rd_select,
    output logic              chan_rdreq,
    output logic              WR,
    output logic [15:0]       fifodata,
    output logic [7:0]        debugbus
);

    // Source index of the command channel and fixed packet geometry
    localparam logic [3:0] CMD_SEL       = 4'(NUM_CHAN);
    localparam logic [9:0] PAYLOAD_WORDS = 10'd252;
    localparam logic [7:0] LAST_WORD     = 8'd251;
    localparam logic [8:0] PAYLOAD_BYTES = 9'd504;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR1    = 3'd1,
        HDR2    = 3'd2,
        TS_LO   = 3'd3,
        TS_HI   = 3'd4,
        FORWARD = 3'd5
    } state_t;

    state_t      state;
    logic [7:0]  word_cnt;
    logic [31:0] ts_latch;

    logic        is_cmd;
    logic        data_eligible;
    logic        cmd_has_word;
    logic        src_ready;
    logic [3:0]  next_sel;
    logic [5:0]  sel_rssi;
    logic        sel_underrun;
    logic [4:0]  sel_chan;
    logic [15:0] hdr_word0;
    logic [15:0] hdr_word1;
    logic [15:0] fwd_word;

    // Source classification and readiness of the currently selected source
    assign is_cmd        = (rd_select == CMD_SEL);
    assign data_eligible = (rd_select < channels) && (rd_select < CMD_SEL);
    assign cmd_has_word  = !chan_empty[NUM_CHAN];
    assign src_ready     = is_cmd ? cmd_has_word
                                  : (data_eligible && (chan_usedw >= PAYLOAD_WORDS));
    assign next_sel      = is_cmd ? 4'd0 : (rd_select + 4'd1);

    // Per-source header fields; the command channel reports no RSSI/underrun
    always_comb begin
        sel_rssi     = 6'd0;
        sel_underrun = 1'b0;
        if (!is_cmd) begin
            case (rd_select)
                4'd0:    sel_rssi = rssi_0[5:0];
                4'd1:    sel_rssi = rssi_1[5:0];
                4'd2:    sel_rssi = rssi_2[5:0];
                4'd3:    sel_rssi = rssi_3[5:0];
                default: sel_rssi = 6'd0;
            endcase
            case (rd_select)
                4'd0:    sel_underrun = underrun[0];
                4'd1:    sel_underrun = underrun[1];
                default: sel_underrun = 1'b0;
            endcase
        end
    end

    assign sel_chan  = is_cmd ? 5'h1F : {1'b0, rd_select};
    // {overrun, underrun, dropped, burst, rssi, chan}
    assign hdr_word0 = {1'b0, sel_underrun, 1'b0, 2'b11, sel_rssi, sel_chan};
    // {mbz, tag, payload_len}
    assign hdr_word1 = {3'b000, 4'h0, PAYLOAD_BYTES};

    // Command packets are zero-padded once the reply FIFO runs dry
    assign fwd_word   = (is_cmd && !cmd_has_word) ? 16'h0000 : chan_fifodata;
    assign chan_rdreq = (state == FORWARD) && (!is_cmd || cmd_has_word);

    assign debugbus = {state, rd_select, WR};

    // Packet sequencer: scan sources in IDLE, then emit 256 back-to-back words
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state     <= IDLE;
            rd_select <= 4'd0;
            WR        <= 1'b0;
            fifodata  <= 16'h0000;
            word_cnt  <= 8'd0;
            ts_latch  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    WR       <= 1'b0;
                    word_cnt <= 8'd0;
                    if (src_ready && have_space) begin
                        state    <= HDR1;
                        ts_latch <= adctime;
                    end else begin
                        rd_select <= next_sel;
                    end
                end
                HDR1: begin
                    WR       <= 1'b1;
                    fifodata <= hdr_word0;
                    state    <= HDR2;
                end
                HDR2: begin
                    WR       <= 1'b1;
                    fifodata <= hdr_word1;
                    state    <= TS_LO;
                end
                TS_LO: begin
                    WR       <= 1'b1;
                    fifodata <= ts_latch[15:0];
                    state    <= TS_HI;
                end
                TS_HI: begin
                    WR       <= 1'b1;
                    fifodata <= ts_latch[31:16];
                    state    <= FORWARD;
                end
                FORWARD: begin
                    WR       <= 1'b1;
                    fifodata <= fwd_word;
                    if (word_cnt == LAST_WORD) begin
                        state     <= IDLE;
                        word_cnt  <= 8'd0;
                        rd_select <= next_sel;
                    end else begin
                        word_cnt <= word_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    WR    <= 1'b0;
                end
            endcase
        end
    end

    // Input bits that carry no information for this block
    logic unused_ok;
    assign unused_ok = &{1'b0, chan_empty[NUM_CHAN-1:0], rssi_0[31:6],
                         rssi_1[31:6], rssi_2[31:6], rssi_3[31:6]};

endmodule
`default_nettype wire

// File: tb/tb_rx_packet_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_packet_builder
// Purpose  : Self-checking bench for rx_packet_builder (NUM_CHAN=1). Models
//            the data and command FIFOs and scoreboards every USB FIFO word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_packet_builder;

    logic        rxclk;
    logic        reset;
    logic [31:0] adctime;
    logic [3:0]  channels;
    logic [15:0] chan_fifodata;
    logic [1:0]  chan_empty;
    logic [9:0]  chan_usedw;
    logic        have_space;
    logic [31:0] rssi_0, rssi_1, rssi_2, rssi_3;
    logic [1:0]  underrun;
    logic [3:0]  rd_select;
    logic        chan_rdreq;
    logic        WR;
    logic [15:0] fifodata;
    logic [7:0]  debugbus;

    rx_packet_builder #(.NUM_CHAN(1)) dut (
        .rxclk         (rxclk),
        .reset         (reset),
        .adctime       (adctime),
        .channels      (channels),
        .chan_fifodata (chan_fifodata),
        .chan_empty    (chan_empty),
        .chan_usedw    (chan_usedw),
        .have_space    (have_space),
        .rssi_0        (rssi_0),
        .rssi_1        (rssi_1),
        .rssi_2        (rssi_2),
        .rssi_3        (rssi_3),
        .underrun      (underrun),
        .rd_select     (rd_select),
        .chan_rdreq    (chan_rdreq),
        .WR            (WR),
        .fifodata      (fifodata),
        .debugbus      (debugbus)
    );

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] data_q[$];
    logic [15:0] cmd_q[$];
    logic [15:0] exp_q[$];
    bit          cmd_en = 1'b0;
    int          cmd_pops = 0;
    int          run_len = 0;
    bit          abandon = 1'b0;
    logic        rq;
    logic [3:0]  rs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] hdr0(input logic u, input logic [5:0] r, input logic [4:0] c);
        return {1'b0, u, 1'b0, 2'b11, r, c};
    endfunction

    // FIFO model: remember the pop request of the cycle, pop after the edge
    always @(negedge rxclk) begin
        rq = chan_rdreq;
        rs = rd_select;
    end

    always @(posedge rxclk) begin
        #1;
        if (rq) begin
            if (rs == 4'd0) begin
                if (data_q.size() > 0) data_q.delete(0);
            end else begin
                cmd_pops++;
                if (cmd_q.size() > 0) cmd_q.delete(0);
            end
        end
        chan_empty[0] = (data_q.size() == 0);
        chan_empty[1] = !cmd_en || (cmd_q.size() == 0);
        if (rd_select == 4'd0) begin
            chan_fifodata = (data_q.size() > 0) ? data_q[0] : 16'hDEAD;
            chan_usedw    = (data_q.size() > 1023) ? 10'd1023 : 10'(data_q.size());
        end else begin
            chan_fifodata = (cmd_q.size() > 0) ? cmd_q[0] : 16'hDEAD;
            chan_usedw    = 10'(cmd_q.size());
        end
    end

    // Output monitor: every written word must match the scoreboard head
    always @(negedge rxclk) begin
        if (WR) begin
            if (exp_q.size() == 0) check_eq("unexpected_wr", 32'(fifodata), 32'hFFFF_FFFF);
            else                   check_eq("word", 32'(fifodata), 32'(exp_q.pop_front()));
            run_len++;
        end else if (run_len != 0) begin
            if (!abandon) check_eq("pkt_len", run_len, 256);
            abandon = 1'b0;
            run_len = 0;
        end
    end

    task automatic at_cycle();
        @(posedge rxclk);
        #2;
    endtask

    task automatic load_data(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) data_q.push_back(base + 16'(i));
    endtask

    task automatic exp_hdr(input logic [15:0] h0, input logic [31:0] ts);
        exp_q.push_back(h0);
        exp_q.push_back(16'h01F8);
        exp_q.push_back(ts[15:0]);
        exp_q.push_back(ts[31:16]);
    endtask

    task automatic exp_data_pkt(input logic [15:0] h0, input logic [31:0] ts, input logic [15:0] base);
        exp_hdr(h0, ts);
        for (int i = 0; i < 252; i++) exp_q.push_back(base + 16'(i));
    endtask

    task automatic exp_cmd_pkt(input logic [31:0] ts, input logic [15:0] w0,
                               input int n);
        exp_hdr(16'h181F, ts);
        for (int i = 0; i < 252; i++) exp_q.push_back((i < n) ? (w0 + 16'(i)) : 16'h0000);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge rxclk);
            if (exp_q.size() == 0 && run_len == 0 && !WR) break;
        end
        check_eq({"drain_", tag}, exp_q.size(), 0);
    endtask

    task automatic count_wr(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge rxclk);
            if (WR) seen++;
        end
        check_eq(tag, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; adctime = 32'd0; channels = 4'd1; have_space = 1'b1;
        rssi_0 = 32'd0; rssi_1 = 32'd0; rssi_2 = 32'd0; rssi_3 = 32'd0;
        underrun = 2'b00; chan_fifodata = 16'h0; chan_empty = 2'b11; chan_usedw = 10'd0;
        repeat (3) @(posedge rxclk);
        @(negedge rxclk);
        check_eq("rst_wr", 32'(WR), 0);
        check_eq("rst_data", 32'(fifodata), 0);
        check_eq("rst_rdreq", 32'(chan_rdreq), 0);
        check_eq("rst_rdsel", 32'(rd_select), 0);
        check_eq("rst_dbg", 32'(debugbus), 0);
        at_cycle();
        reset = 1'b0;

        // Idle: round-robin scan with nothing to send
        for (int i = 0; i < 4; i++) begin
            @(negedge rxclk);
            check_eq("idle_rdsel", 32'(rd_select), 32'(i % 2));
        end
        count_wr("idle_no_wr", 100);

        // Data channel 0 packet
        adctime = 32'h1234_5678; rssi_0 = 32'h0A;
        at_cycle();
        load_data(252, 16'h0001);
        exp_q.push_back(16'h1940); exp_q.push_back(16'h01F8);
        exp_q.push_back(16'h5678); exp_q.push_back(16'h1234);
        for (int i = 1; i <= 252; i++) exp_q.push_back(16'(i));
        drain("ch0", 700);

        // Command packet with zero padding
        adctime = 32'h0BAD_F00D;
        at_cycle();
        cmd_pops = 0;
        cmd_q.push_back(16'hAAAA); cmd_q.push_back(16'hBBBB); cmd_q.push_back(16'hCCCC);
        cmd_en = 1'b1;
        exp_hdr(16'h181F, 32'h0BAD_F00D);
        exp_q.push_back(16'hAAAA); exp_q.push_back(16'hBBBB); exp_q.push_back(16'hCCCC);
        for (int i = 0; i < 249; i++) exp_q.push_back(16'h0000);
        drain("cmd", 700);
        check_eq("cmd_pops", cmd_pops, 3);

        // Both sources ready, held off by have_space
        have_space = 1'b0; adctime = 32'hCAFE_0001;
        at_cycle();
        load_data(504, 16'h1000);
        for (int i = 0; i < 5; i++) cmd_q.push_back(16'h5000 + 16'(i));
        count_wr("hold_no_wr", 50);
        @(negedge rxclk);
        rs = rd_select;
        @(negedge rxclk);
        check_eq("hold_rr", 32'(rd_select), 32'(rs ^ 4'd1));
        exp_data_pkt(hdr0(1'b0, 6'h0A, 5'd0), 32'hCAFE_0001, 16'h1000);
        exp_cmd_pkt(32'hCAFE_0001, 16'h5000, 5);
        exp_data_pkt(hdr0(1'b0, 6'h0A, 5'd0), 32'hCAFE_0001, 16'h10FC);
        for (int i = 0; i < 10; i++) begin
            at_cycle();
            if (rd_select == 4'd0) break;
        end
        have_space = 1'b1;
        drain("alt", 2000);

        // Reset in the middle of the payload
        adctime = 32'h0000_1111;
        at_cycle();
        load_data(252, 16'h0100);
        exp_data_pkt(16'h1940, 32'h0000_1111, 16'h0100);
        for (int i = 0; i < 600; i++) begin
            @(posedge rxclk);
            #1;
            if (run_len >= 104) break;
        end
        check_eq("reach_w100", 32'(run_len >= 104), 1);
        abandon = 1'b1;
        reset = 1'b1;
        @(posedge rxclk);
        #2;
        data_q.delete();
        exp_q.delete();
        @(negedge rxclk);
        check_eq("midrst_wr", 32'(WR), 0);
        check_eq("midrst_state", 32'(debugbus[7:5]), 0);
        check_eq("midrst_rdreq", 32'(chan_rdreq), 0);
        load_data(252, 16'h0200);
        exp_data_pkt(16'h1940, 32'h0000_1111, 16'h0200);
        at_cycle();
        reset = 1'b0;
        drain("after_rst", 700);

        // Underrun flag on channel 0
        underrun = 2'b01; rssi_0 = 32'hFFFF_FF15; adctime = 32'h00AB_00CD;
        at_cycle();
        load_data(252, 16'h0300);
        exp_data_pkt(16'h5AA0, 32'h00AB_00CD, 16'h0300);
        drain("underrun", 700);
        underrun = 2'b00;

        // No active data channels: only command packets
        channels = 4'd0; adctime = 32'h7777_8888;
        at_cycle();
        load_data(252, 16'h0400);
        cmd_q.push_back(16'h7777); cmd_q.push_back(16'h8888);
        exp_cmd_pkt(32'h7777_8888, 16'h7777, 1);
        exp_q[5] = 16'h8888;
        drain("chan0", 700);
        count_wr("chan0_quiet", 600);
        check_eq("chan0_unread", data_q.size(), 252);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
